// File: rtl/ahb_lite_single_initiator_if.sv
// AHB-Lite point-to-point bus between the single initiator (master) and one responder (slave).
interface ahb_lite_single_initiator_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] haddr;
  logic [DW-1:0] hwdata;
  logic          hsel;
  logic          hwrite;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic          hready;
  logic          hreadyout;
  logic          hresp;
  logic [DW-1:0] hrdata;

  modport master (
    output haddr, hwdata, hsel, hwrite, htrans, hsize, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  haddr, hwdata, hsel, hwrite, htrans, hsize, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_lite_single_initiator.sv
// Single-outstanding AHB-Lite initiator: valid/ready request in, one-cycle response pulse out,
// with a per-phase wait-state timeout so a hung responder cannot stall the requester.
//
// state | meaning
// IDLE  | req_ready=1, waiting for a request
// ADDR  | NONSEQ address phase on the bus
// DATA  | data phase, waiting for hreadyout
// RSP   | rsp_valid pulse, response fields updated
module ahb_lite_single_initiator #(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [AHB_ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]                req_size,
  input  logic [AHB_DATA_WIDTH-1:0] req_wdata,
  output logic                      rsp_valid,
  output logic                      rsp_error,
  output logic                      rsp_timeout,
  output logic [AHB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      busy_o,
  ahb_lite_single_initiator_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RSP  = 2'd3;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam int         MAX_SIZE   = $clog2(AHB_DATA_WIDTH / 8);
  localparam logic [2:0] MAX_SIZE_L = 3'(MAX_SIZE);

  localparam int             CW         = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int             TMO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0]  TMO_LAST   = CW'(TMO_LAST_I);

  logic [1:0]                state;
  logic                      lat_write;
  logic [AHB_DATA_WIDTH-1:0] lat_wdata;
  logic [AHB_ADDR_WIDTH-1:0] haddr_q;
  logic                      hwrite_q;
  logic [2:0]                hsize_q;
  logic                      hsel_q;
  logic [1:0]                htrans_q;
  logic [AHB_DATA_WIDTH-1:0] hwdata_q;
  logic [CW-1:0]             tmo_cnt;
  logic                      tmo_hit;
  logic [2:0]                align_mask;
  logic                      misaligned;

  always_comb begin
    align_mask = 3'b000;
    case (req_size[1:0])
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
    misaligned = (req_size > MAX_SIZE_L) || (|(req_addr[2:0] & align_mask));
  end

  // A zero TIMEOUT_CYCLES disables the abort path entirely.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && !bus.hreadyout && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      lat_write   <= 1'b0;
      lat_wdata   <= '0;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'd0;
      hsel_q      <= 1'b0;
      htrans_q    <= HTRANS_IDLE;
      hwdata_q    <= '0;
      tmo_cnt     <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_wdata <= req_wdata;
            if (misaligned) begin
              state       <= S_RSP;
              rsp_error   <= 1'b1;
              rsp_timeout <= 1'b0;
              rsp_rdata   <= '0;
            end else begin
              state    <= S_ADDR;
              hsel_q   <= 1'b1;
              htrans_q <= HTRANS_NONSEQ;
              haddr_q  <= req_addr;
              hwrite_q <= req_write;
              hsize_q  <= req_size;
              tmo_cnt  <= '0;
            end
          end
        end
        S_ADDR: begin
          if (bus.hreadyout) begin
            state    <= S_DATA;
            hsel_q   <= 1'b0;
            htrans_q <= HTRANS_IDLE;
            hwdata_q <= lat_write ? lat_wdata : '0;
            tmo_cnt  <= '0;
          end else if (tmo_hit) begin
            state       <= S_RSP;
            hsel_q      <= 1'b0;
            htrans_q    <= HTRANS_IDLE;
            rsp_error   <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        S_DATA: begin
          // hresp with hreadyout low is the first error cycle; treat it as a plain wait state.
          if (bus.hreadyout) begin
            state       <= S_RSP;
            hwdata_q    <= '0;
            rsp_error   <= bus.hresp;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= (!lat_write && !bus.hresp) ? bus.hrdata : '0;
          end else if (tmo_hit) begin
            state       <= S_RSP;
            hwdata_q    <= '0;
            rsp_error   <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state == S_IDLE);
  assign busy_o     = (state != S_IDLE);
  assign rsp_valid  = (state == S_RSP);

  assign bus.haddr  = haddr_q;
  assign bus.hwrite = hwrite_q;
  assign bus.hsize  = hsize_q;
  assign bus.hsel   = hsel_q;
  assign bus.htrans = htrans_q;
  assign bus.hwdata = hwdata_q;
  assign bus.hready = bus.hreadyout;

endmodule
